// File: rtl/wcmd_gen.sv
// Weight-fetch command generator: column index -> 80-bit DataMover read cmd.
// Ports: cfg_*, s_axis_* (index in), m_axis_* (cmd out), wdat_done, ts_done, outstanding, err_underflow.
module wcmd_gen #(
  parameter int NUM_PE        = 8,
  parameter int LAYER_SIZE_BW = 10,
  parameter int ADDR_BW       = 32,
  parameter int MAX_OUT       = 2
) (
  input  logic                     s_axi_aclk,
  input  logic                     s_axi_areset,
  input  logic [ADDR_BW-1:0]       cfg_base_addr,
  input  logic [22:0]              cfg_col_bytes,
  input  logic                     s_axis_tvalid,
  output logic                     s_axis_tready,
  input  logic [LAYER_SIZE_BW-1:0] s_axis_tdata,
  input  logic                     s_axis_tuser,
  input  logic                     s_axis_tlast,
  output logic                     m_axis_tvalid,
  input  logic                     m_axis_tready,
  output logic [79:0]              m_axis_tdata,
  input  logic                     wdat_done,
  output logic                     ts_done,
  output logic [3:0]               outstanding,
  output logic                     err_underflow
);

  localparam int PW = LAYER_SIZE_BW + 23;
  localparam logic [22:0] BEAT_MASK = ~23'(NUM_PE - 1);
  localparam logic [3:0] MAX_O = 4'(MAX_OUT);

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    ISSUE,
    DRAIN
  } state_t;

  state_t state, state_nxt;

  logic [LAYER_SIZE_BW-1:0] idx_q;
  logic [ADDR_BW-1:0]       base_q;
  logic [22:0]              btt_q;
  logic                     last_q;
  logic [3:0]               tag;
  logic [79:0]              cmd_q;
  logic [ADDR_BW-1:0]       saddr;
  logic [31:0]              saddr32;
  logic                     in_hs;
  logic                     cmd_hs;

  // Address arithmetic wraps modulo the address width.
  assign saddr   = base_q + ADDR_BW'(PW'(idx_q) * PW'(btt_q));
  assign saddr32 = 32'(saddr);

  assign in_hs  = s_axis_tvalid & s_axis_tready;
  assign cmd_hs = m_axis_tvalid & m_axis_tready;

  assign m_axis_tdata = cmd_q;

  always_comb begin
    state_nxt     = state;
    s_axis_tready = 1'b0;
    m_axis_tvalid = 1'b0;
    ts_done       = 1'b0;
    unique case (state)
      IDLE: begin
        s_axis_tready = !s_axi_areset && (outstanding < MAX_O);
        if (s_axis_tvalid && s_axis_tready)
          state_nxt = s_axis_tuser ? DRAIN : CALC;
      end
      CALC: state_nxt = ISSUE;
      ISSUE: begin
        m_axis_tvalid = 1'b1;
        if (m_axis_tready)
          state_nxt = last_q ? DRAIN : IDLE;
      end
      DRAIN: begin
        if (outstanding == 4'd0) begin
          ts_done   = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge s_axi_aclk) begin
    if (s_axi_areset) begin
      state         <= IDLE;
      idx_q         <= '0;
      base_q        <= '0;
      btt_q         <= '0;
      last_q        <= 1'b0;
      cmd_q         <= '0;
      tag           <= '0;
      outstanding   <= '0;
      err_underflow <= 1'b0;
    end else begin
      state <= state_nxt;
      if (in_hs) begin
        idx_q  <= s_axis_tdata;
        base_q <= cfg_base_addr;
        // BTT is always a whole number of weight beats.
        btt_q  <= cfg_col_bytes & BEAT_MASK;
        // An empty beat always closes the timestep.
        last_q <= s_axis_tlast | s_axis_tuser;
      end
      if (state == CALC)
        cmd_q <= {12'h000, tag, saddr32, 1'b0, 1'b1,
                  6'h00, 1'b1, btt_q};
      if (cmd_hs)
        tag <= tag + 4'd1;
      unique case ({cmd_hs, wdat_done})
        2'b10: outstanding <= outstanding + 4'd1;
        2'b01: begin
          if (outstanding == 4'd0)
            err_underflow <= 1'b1;
          else
            outstanding <= outstanding - 4'd1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_wcmd_gen.sv
// Directed bench for wcmd_gen: cycle vector table plus corner sequences.
// Drives inputs 1ns after the rising edge, samples on the falling edge or +1ns.
module tb_wcmd_gen;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] base;
  logic [22:0] colb;
  logic        sv;
  logic        srdy;
  logic [9:0]  sd;
  logic        su;
  logic        sl;
  logic        mv;
  logic        mrdy;
  logic [79:0] mdat;
  logic        wd;
  logic        ts;
  logic [3:0]  outs;
  logic        err;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  logic [3:0]  exp_tag;
  logic [79:0] d;
  int a, t, w, n;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  wcmd_gen dut (
    .s_axi_aclk   (clk),
    .s_axi_areset (rst),
    .cfg_base_addr(base),
    .cfg_col_bytes(colb),
    .s_axis_tvalid(sv),
    .s_axis_tready(srdy),
    .s_axis_tdata (sd),
    .s_axis_tuser (su),
    .s_axis_tlast (sl),
    .m_axis_tvalid(mv),
    .m_axis_tready(mrdy),
    .m_axis_tdata (mdat),
    .wdat_done    (wd),
    .ts_done      (ts),
    .outstanding  (outs),
    .err_underflow(err)
  );

  typedef struct {
    logic        v;
    logic [9:0]  idx;
    logic        u;
    logic        l;
    logic        wd;
    logic        e_trdy;
    logic        e_mv;
    logic [79:0] e_dat;
    logic        e_ts;
    logic [3:0]  e_out;
  } vec_t;

  vec_t tab[24];

  function automatic logic [79:0] cmd(input logic [31:0] sa,
                                      input logic [3:0] tg);
    return {12'h000, tg, sa, 1'b0, 1'b1, 6'h00, 1'b1, 23'd64};
  endfunction

  function automatic vec_t mk(int v, int idx, int u, int l, int w_,
                              int tr, int m, logic [79:0] dd,
                              int tsx, int o);
    vec_t r;
    r.v = 1'(v); r.idx = 10'(idx); r.u = 1'(u); r.l = 1'(l);
    r.wd = 1'(w_); r.e_trdy = 1'(tr); r.e_mv = 1'(m);
    r.e_dat = dd; r.e_ts = 1'(tsx); r.e_out = 4'(o);
    return r;
  endfunction

  task automatic chk(input string nm, input logic [79:0] got,
                     input logic [79:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
    end
  endtask

  task automatic timeout(input string nm);
    checks++;
    failures++;
    $display("FAIL %s timeout got=none exp=event", nm);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wd_pulse();
    wd = 1'b1;
    step();
    wd = 1'b0;
  endtask

  task automatic accept(input logic [9:0] i, input logic l,
                        input logic u, output int at);
    sv = 1'b1; sd = i; sl = l; su = u;
    at = -1;
    for (int k = 0; k < 50; k++) begin
      if (srdy) begin
        at = cyc;
        break;
      end
      step();
    end
    if (at < 0) timeout("accept");
    step();
    sv = 1'b0; sl = 1'b0; su = 1'b0;
  endtask

  task automatic issue(input logic [9:0] i, input logic l,
                       input logic [31:0] sa, output int tt);
    int at;
    accept(i, l, 1'b0, at);
    mrdy = 1'b1;
    tt = -1;
    for (int k = 0; k < 50; k++) begin
      if (mv) begin
        tt = cyc;
        chk($sformatf("cmd_data_idx%0d", i), mdat, cmd(sa, exp_tag));
        break;
      end
      step();
    end
    if (tt < 0) timeout("cmd_wait");
    else begin
      chk("cmd_latency", 80'(tt - at), 80'd2);
      exp_tag = exp_tag + 4'd1;
    end
    step();
  endtask

  initial begin
    tab[0]  = mk(1, 3, 0, 0, 0, 1, 0, 0, 0, 0);
    tab[1]  = mk(1, 7, 0, 1, 0, 0, 0, 0, 0, 0);
    tab[2]  = mk(1, 7, 0, 1, 0, 0, 1, cmd(32'h10C0, 4'd0), 0, 0);
    tab[3]  = mk(1, 7, 0, 1, 0, 1, 0, 0, 0, 1);
    tab[4]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    tab[5]  = mk(0, 0, 0, 0, 0, 0, 1, cmd(32'h11C0, 4'd1), 0, 1);
    tab[6]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 2);
    tab[7]  = mk(0, 0, 0, 0, 1, 0, 0, 0, 0, 2);
    tab[8]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    tab[9]  = mk(0, 0, 0, 0, 1, 0, 0, 0, 0, 1);
    tab[10] = mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    tab[11] = mk(0, 0, 0, 0, 0, 1, 0, 0, 0, 0);
    tab[12] = mk(1, 0, 1, 1, 0, 1, 0, 0, 0, 0);
    tab[13] = mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    tab[14] = mk(0, 0, 0, 0, 0, 1, 0, 0, 0, 0);
    tab[15] = mk(1, 0, 0, 0, 0, 1, 0, 0, 0, 0);
    tab[16] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    tab[17] = mk(0, 0, 0, 0, 0, 0, 1, cmd(32'h1000, 4'd2), 0, 0);
    tab[18] = mk(1, 1, 0, 1, 0, 1, 0, 0, 0, 1);
    tab[19] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    tab[20] = mk(0, 0, 0, 0, 1, 0, 1, cmd(32'h1040, 4'd3), 0, 1);
    tab[21] = mk(0, 0, 0, 0, 1, 0, 0, 0, 0, 1);
    tab[22] = mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    tab[23] = mk(0, 0, 0, 0, 0, 1, 0, 0, 0, 0);

    rst = 1'b1; base = 32'h1000; colb = 23'd64;
    sv = 0; sd = 0; su = 0; sl = 0; mrdy = 1'b1; wd = 0;
    repeat (3) step();
    chk("rst_tready", srdy, 0);
    chk("rst_mvalid", mv, 0);
    chk("rst_mdata", mdat, 0);
    chk("rst_ts_done", ts, 0);
    chk("rst_outstanding", outs, 0);
    chk("rst_err", err, 0);
    rst = 1'b0;
    step();
    chk("post_rst_tready", srdy, 1);

    // Cycle-exact trace: two indices, empty beat, issue+done overlap.
    for (int r = 0; r < 24; r++) begin
      sv = tab[r].v; sd = tab[r].idx; su = tab[r].u;
      sl = tab[r].l; wd = tab[r].wd;
      @(negedge clk);
      chk($sformatf("row%0d_tready", r), srdy, tab[r].e_trdy);
      chk($sformatf("row%0d_mvalid", r), mv, tab[r].e_mv);
      if (tab[r].e_mv)
        chk($sformatf("row%0d_mdata", r), mdat, tab[r].e_dat);
      chk($sformatf("row%0d_ts_done", r), ts, tab[r].e_ts);
      chk($sformatf("row%0d_outstanding", r), outs, tab[r].e_out);
      @(posedge clk);
      #1;
    end
    sv = 0; su = 0; sl = 0; wd = 0;
    exp_tag = 4'd4;

    // Throttle at MAX_OUT outstanding.
    issue(10'd1, 1'b0, 32'h1040, t);
    issue(10'd2, 1'b0, 32'h1080, t);
    sv = 1'b1; sd = 10'd3; n = 0;
    for (int k = 0; k < 5; k++) begin
      if (srdy || mv) n++;
      step();
    end
    chk("throttle_hold", 80'(n), 0);
    chk("throttle_out", outs, 2);
    w = cyc;
    wd_pulse();
    chk("room_after_done", srdy, 1);
    issue(10'd3, 1'b0, 32'h10C0, t);
    chk("third_cmd_delay", 80'(t - w), 3);
    wd_pulse();
    issue(10'd4, 1'b1, 32'h1100, t);
    wd_pulse();
    chk("drain_wait_ts", ts, 0);
    wd_pulse();
    chk("drain_ts", ts, 1);
    step();
    chk("drain_ts_end", ts, 0);

    // Backpressure in ISSUE; cfg change after handshake is ignored.
    mrdy = 1'b0;
    accept(10'd5, 1'b0, 1'b0, a);
    step();
    chk("bp_mvalid", mv, 1);
    d = mdat;
    chk("bp_data", d, cmd(32'h1140, exp_tag));
    base = 32'h2000; sv = 1'b1; sd = 10'd6; sl = 1'b1; n = 0;
    for (int k = 0; k < 5; k++) begin
      step();
      if (!mv || mdat !== d || srdy) n++;
    end
    chk("bp_hold", 80'(n), 0);
    mrdy = 1'b1;
    step();
    exp_tag = exp_tag + 4'd1;
    issue(10'd6, 1'b1, 32'h2180, t);
    wd_pulse();
    wd_pulse();
    chk("bp_ts", ts, 1);
    step();

    // Address wraps modulo 2^32.
    base = 32'hFFFF_FFC0;
    issue(10'd2, 1'b0, 32'h0000_0040, t);
    wd_pulse();
    base = 32'h1000;

    // Underflow is sticky and leaves the counter at 0.
    chk("uf_before", err, 0);
    wd_pulse();
    chk("uf_set", err, 1);
    chk("uf_out", outs, 0);
    repeat (3) step();
    chk("uf_sticky", err, 1);

    // Reset while a command waits in ISSUE.
    issue(10'd8, 1'b0, 32'h1200, t);
    mrdy = 1'b0;
    accept(10'd9, 1'b0, 1'b0, a);
    step();
    chk("rst2_pre_mvalid", mv, 1);
    rst = 1'b1;
    step();
    chk("rst2_mvalid", mv, 0);
    chk("rst2_mdata", mdat, 0);
    chk("rst2_out", outs, 0);
    chk("rst2_err", err, 0);
    chk("rst2_tready", srdy, 0);
    rst = 1'b0;
    step();
    chk("rst2_tready_after", srdy, 1);
    mrdy = 1'b1; n = 0;
    for (int k = 0; k < 4; k++) begin
      if (mv) n++;
      step();
    end
    chk("rst2_dropped", 80'(n), 0);
    exp_tag = 4'd0;

    // Tag wraps 15 -> 0 over 17 commands.
    for (int i = 0; i < 17; i++) begin
      issue(10'(i), 1'b0, 32'(32'h1000 + i * 64), t);
      wd_pulse();
    end
    chk("final_out", outs, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/wcmd_gen.md
# wcmd_gen

Weight-fetch command generator sitting directly upstream of the weight memory/DataMover read channel. Each cycle it can accept one nonzero-delta column index from the delta-encoder stream. It converts the index into one 80-bit DataMover read command that fetches that column's weights, with a rolling tag. It throttles on outstanding bursts, counts burst completions from the weight data stream, and pulses `ts_done` once every burst of a timestep has been delivered.

## Interface
- `NUM_PE`, 8: PEs per weight beat; bytes per beat = `NUM_PE` (8-bit weights).
- `LAYER_SIZE_BW`, 10: column index width.
- `ADDR_BW`, 32: byte address width.
- `MAX_OUT`, 2: maximum outstanding commands (1..15).
- `s_axi_aclk`  in  1  clock; all logic on rising edge.
- `s_axi_areset`  in  1  reset, synchronous, active-high.
- `cfg_base_addr`  in  ADDR_BW  byte address of column 0 of the current layer.
- `cfg_col_bytes`  in  23  bytes per column burst; multiple of `NUM_PE`, ≥ 2·`NUM_PE`.
- `s_axis_tvalid`  in  1  column index valid.
- `s_axis_tready`  out  1  index accepted.
- `s_axis_tdata`  in  LAYER_SIZE_BW  column index.
- `s_axis_tuser`  in  1  1 = empty beat (no column, timestep has zero nonzero deltas); only legal with `tlast`.
- `s_axis_tlast`  in  1  last index of timestep.
- `m_axis_tvalid`  out  1  command valid.
- `m_axis_tready`  in  1  command accepted.
- `m_axis_tdata`  out  80  DataMover command.
- `wdat_done`  in  1  one-cycle pulse per completed weight burst (data tlast handshake).
- `ts_done`  out  1  one-cycle pulse, timestep fully fetched.
- `outstanding`  out  4  commands issued and not yet completed.
- `err_underflow`  out  1  sticky: `wdat_done` arrived with `outstanding`==0.

## Operation
- Command fields: [22:0] BTT = `cfg_col_bytes`. [23] = 1 (INCR). [29:24] = 0. [30] EOF = 1. [31] = 0. [63:32] SADDR = `cfg_base_addr` + idx·`cfg_col_bytes`, truncated modulo 2^32. [67:64] tag. [79:68] = 0.
- Multiply is registered. `cfg_*` are sampled on the index handshake; changing them later has no effect on that command.
- Tag: 4-bit counter, +1 per command handshake, wraps 15→0. Reset value 0.
- Outstanding counter:
  - +1 on command handshake.
  - −1 on `wdat_done`.
  - Both in the same cycle: unchanged.
  - `wdat_done` at 0: counter stays 0 and `err_underflow` sets.
- FSM states:
  - IDLE: `s_axis_tready` = (`outstanding` < `MAX_OUT`). On handshake, go to CALC. An empty beat (tuser=1) goes straight to DRAIN.
  - CALC: one cycle; register SADDR. Go to ISSUE.
  - ISSUE: `m_axis_tvalid`=1, with data held stable until `m_axis_tready`. On handshake, go to DRAIN if the accepted index had tlast, otherwise IDLE.
  - DRAIN: wait for `outstanding`==0. In that cycle pulse `ts_done` and go to IDLE.
- tuser=1 without tlast is illegal. The beat is treated as tlast.

## Timing
- Reset values:
  - FSM IDLE.
  - `s_axis_tready`=0 during reset, 1 in the first cycle after.
  - `m_axis_tvalid`=0, `m_axis_tdata`=0.
  - `ts_done`=0, `outstanding`=0, tag=0, `err_underflow`=0.
- Index handshake at cycle N → `m_axis_tvalid` high at N+2. Maximum throughput is one command per 3 cycles (IDLE/CALC/ISSUE).
- `s_axis_tready` is 0 in CALC, ISSUE and DRAIN.
- `outstanding` is registered. A `wdat_done` at cycle N makes room for the next index at N+1.
- `ts_done` is asserted the cycle after `outstanding` reaches 0 in DRAIN. If DRAIN is entered with `outstanding` already 0, `ts_done` is asserted on the first DRAIN cycle.
- Reset mid-burst: all state is cleared, and any pending command is dropped without being issued.

## Test plan
- base=0x1000, col_bytes=64, indices 3,7(tlast), ready=1, `wdat_done` 10 cycles after each command → SADDR 0x10C0 then 0x11C0, BTT=64, tags 0,1, exactly one `ts_done` after the 2nd `wdat_done`.
- MAX_OUT=2, four indices, `wdat_done` withheld → 2 commands issued, then `s_axis_tready` stays 0 until a `wdat_done`, after which the 3rd command appears 3 cycles later.
- `m_axis_tready` low for 5 cycles during ISSUE → tvalid/tdata held constant, and no second index is accepted.
- Empty beat (tuser=1, tlast=1) with `outstanding`=0 → no command issued, `ts_done` at handshake+1.
- 17 commands → tag sequence 0..15,0. Issuing a command and `wdat_done` in the same cycle → `outstanding` unchanged. `wdat_done` at 0 → `err_underflow`=1 and stays set.
- base=0xFFFFFFC0, idx=2, col_bytes=64 → SADDR=0x00000040 (wrap). Reset asserted during ISSUE → tvalid=0 next cycle, all counters 0.
